// File: rtl/wait_buffer_drain.sv
// Drains the wait buffer against a refilled cache line: walks every buffered entry of the
// line, merging stores and answering loads in order, then writes the merged line back.
module wait_buffer_drain #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_WIDTH    = 256,
  parameter int BLOCK_ID_START = 5,
  parameter int MICROOP        = 5,
  parameter int R_WIDTH        = 6,
  parameter int ROB_TICKET     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fill_valid,
  output logic                   fill_ready,
  input  logic [ADDR_BITS-1:0]   fill_address,
  input  logic [BLOCK_WIDTH-1:0] fill_line,
  output logic [ADDR_BITS-1:0]   wb_search_address,
  output logic                   wb_search_invalidate,
  input  logic                   wb_found_one,
  input  logic                   wb_found_multi,
  input  logic                   wb_entry_is_store,
  input  logic [ADDR_BITS-1:0]   wb_entry_address,
  input  logic [DATA_WIDTH-1:0]  wb_entry_data,
  input  logic [MICROOP-1:0]     wb_entry_microop,
  input  logic [R_WIDTH-1:0]     wb_entry_dest,
  input  logic [ROB_TICKET-1:0]  wb_entry_ticket,
  output logic                   rsp_valid,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic [R_WIDTH-1:0]     rsp_dest,
  output logic [ROB_TICKET-1:0]  rsp_ticket,
  output logic                   line_wr_valid,
  output logic [ADDR_BITS-1:0]   line_wr_address,
  output logic [BLOCK_WIDTH-1:0] line_wr_data,
  output logic                   busy
);

  localparam int OFF = BLOCK_ID_START;

  localparam logic [MICROOP-1:0] OP_LW  = 5'b00001;
  localparam logic [MICROOP-1:0] OP_LH  = 5'b00010;
  localparam logic [MICROOP-1:0] OP_LHU = 5'b00011;
  localparam logic [MICROOP-1:0] OP_LB  = 5'b00100;
  localparam logic [MICROOP-1:0] OP_LBU = 5'b00101;
  localparam logic [MICROOP-1:0] OP_SW  = 5'b00110;
  localparam logic [MICROOP-1:0] OP_SH  = 5'b00111;
  localparam logic [MICROOP-1:0] OP_SB  = 5'b01000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WALK  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [BLOCK_WIDTH-1:0] line_r, line_s;
  logic [OFF-1:0]         off_s, hoff_s, woff_s;
  logic [7:0]             b_s;
  logic [15:0]            h_s;
  logic [31:0]            w_s;
  logic                   is_load_s;
  logic [DATA_WIDTH-1:0]  load_data_s;
  logic                   accept_s;
  logic                   unused_s;

  assign accept_s = fill_valid && (state_r == IDLE);
  // Store/load selection is by microop only; the tag part of entry addresses is not re-checked.
  assign unused_s = ^{wb_entry_is_store, fill_address[OFF-1:0], wb_entry_address[ADDR_BITS-1:OFF]};

  // Entry decode: load extraction and store merge against the current line register
  always_comb begin
    off_s       = wb_entry_address[OFF-1:0];
    hoff_s      = {off_s[OFF-1:1], 1'b0};
    woff_s      = {off_s[OFF-1:2], 2'b00};
    b_s         = line_r[{off_s, 3'b000} +: 8];
    h_s         = line_r[{hoff_s, 3'b000} +: 16];
    w_s         = line_r[{woff_s, 3'b000} +: 32];
    is_load_s   = 1'b0;
    load_data_s = {DATA_WIDTH{1'b0}};
    line_s      = line_r;
    case (wb_entry_microop)
      OP_LW:  begin is_load_s = 1'b1; load_data_s = DATA_WIDTH'(w_s); end
      OP_LH:  begin is_load_s = 1'b1; load_data_s = {{(DATA_WIDTH-16){h_s[15]}}, h_s}; end
      OP_LHU: begin is_load_s = 1'b1; load_data_s = DATA_WIDTH'(h_s); end
      OP_LB:  begin is_load_s = 1'b1; load_data_s = {{(DATA_WIDTH-8){b_s[7]}}, b_s}; end
      OP_LBU: begin is_load_s = 1'b1; load_data_s = DATA_WIDTH'(b_s); end
      OP_SW:  line_s[{woff_s, 3'b000} +: 32] = wb_entry_data[31:0];
      OP_SH:  line_s[{hoff_s, 3'b000} +: 16] = wb_entry_data[15:0];
      OP_SB:  line_s[{off_s, 3'b000} +: 8]   = wb_entry_data[7:0];
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (fill_valid) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (wb_found_one) state_s = WALK; else state_s = WRITE;
      WALK:    if (!wb_found_multi) state_s = WRITE; else state_s = WALK;
      WRITE:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched line address and line register (fill load, then in-order merges)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_BITS{1'b0}};
      line_r  <= {BLOCK_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r <= {fill_address[ADDR_BITS-1:OFF], {OFF{1'b0}}};
        line_r <= fill_line;
      end else if (state_r == WALK) begin
        line_r <= line_s;
      end
    end
  end

  assign fill_ready           = (state_r == IDLE);
  assign busy                 = (state_r != IDLE);
  assign wb_search_address    = (state_r == IDLE) ? {ADDR_BITS{1'b0}} : addr_r;
  assign wb_search_invalidate = (state_r == ISSUE) && wb_found_one;
  assign rsp_valid            = (state_r == WALK) && is_load_s;
  assign rsp_data             = rsp_valid ? load_data_s : {DATA_WIDTH{1'b0}};
  assign rsp_dest             = rsp_valid ? wb_entry_dest : {R_WIDTH{1'b0}};
  assign rsp_ticket           = rsp_valid ? wb_entry_ticket : {ROB_TICKET{1'b0}};
  assign line_wr_valid        = (state_r == WRITE);
  assign line_wr_address      = line_wr_valid ? addr_r : {ADDR_BITS{1'b0}};
  assign line_wr_data         = line_wr_valid ? line_r : {BLOCK_WIDTH{1'b0}};

endmodule

// File: tb/tb_wait_buffer_drain.sv
// Randomised and directed bench for wait_buffer_drain: a byte-array line model plus an
// entry queue predicts every output each cycle; a few literal results pin the model.
module tb_wait_buffer_drain;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         fill_valid = 1'b0;
  logic         fill_ready;
  logic [31:0]  fill_address = 32'h0;
  logic [255:0] fill_line = 256'h0;
  logic [31:0]  wb_search_address;
  logic         wb_search_invalidate;
  logic         wb_found_one = 1'b0;
  logic         wb_found_multi = 1'b0;
  logic         wb_entry_is_store = 1'b0;
  logic [31:0]  wb_entry_address = 32'h0;
  logic [31:0]  wb_entry_data = 32'h0;
  logic [4:0]   wb_entry_microop = 5'h0;
  logic [5:0]   wb_entry_dest = 6'h0;
  logic [2:0]   wb_entry_ticket = 3'h0;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [5:0]   rsp_dest;
  logic [2:0]   rsp_ticket;
  logic         line_wr_valid;
  logic [31:0]  line_wr_address;
  logic [255:0] line_wr_data;
  logic         busy;

  wait_buffer_drain dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_address(fill_address), .fill_line(fill_line),
    .wb_search_address(wb_search_address), .wb_search_invalidate(wb_search_invalidate),
    .wb_found_one(wb_found_one), .wb_found_multi(wb_found_multi),
    .wb_entry_is_store(wb_entry_is_store), .wb_entry_address(wb_entry_address),
    .wb_entry_data(wb_entry_data), .wb_entry_microop(wb_entry_microop),
    .wb_entry_dest(wb_entry_dest), .wb_entry_ticket(wb_entry_ticket),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_dest(rsp_dest), .rsp_ticket(rsp_ticket),
    .line_wr_valid(line_wr_valid), .line_wr_address(line_wr_address),
    .line_wr_data(line_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [5:0]  dest;
    logic [2:0]  tk;
  } ent_t;

  ent_t q[$];
  logic [7:0] m [32];

  int vec = 0;
  int errs = 0;
  int rsp_cnt = 0;
  int lw_cnt = 0;
  logic [31:0]  last_rsp = 32'h0;
  logic [255:0] last_line = 256'h0;

  logic         exp_ready = 1'b1, exp_busy = 1'b0, exp_inv = 1'b0;
  logic [31:0]  exp_saddr = 32'h0;
  logic         exp_rsp = 1'b0;
  logic [31:0]  exp_rdata = 32'h0;
  logic [5:0]   exp_rdest = 6'h0;
  logic [2:0]   exp_rtk = 3'h0;
  logic         exp_lw = 1'b0;
  logic [31:0]  exp_lwaddr = 32'h0;
  logic [255:0] exp_lwdata = 256'h0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp_v);
    vec++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model of a load result, read straight from the byte array
  function automatic logic [31:0] model_load(ent_t e);
    int o;
    int b;
    o = int'(e.addr[4:0]);
    case (e.op)
      5'd1: begin b = o - (o % 4); return {m[b+3], m[b+2], m[b+1], m[b]}; end
      5'd2: begin b = o - (o % 2); return {{16{m[b+1][7]}}, m[b+1], m[b]}; end
      5'd3: begin b = o - (o % 2); return {16'h0, m[b+1], m[b]}; end
      5'd4: return {{24{m[o][7]}}, m[o]};
      5'd5: return {24'h0, m[o]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_store(ent_t e);
    int o;
    int b;
    o = int'(e.addr[4:0]);
    case (e.op)
      5'd6: begin b = o - (o % 4); for (int k = 0; k < 4; k++) m[b+k] = e.data[8*k +: 8]; end
      5'd7: begin b = o - (o % 2); for (int k = 0; k < 2; k++) m[b+k] = e.data[8*k +: 8]; end
      5'd8: m[o] = e.data[7:0];
      default: ;
    endcase
  endtask

  function automatic logic [255:0] pack_line();
    logic [255:0] r;
    for (int k = 0; k < 32; k++) r[8*k +: 8] = m[k];
    return r;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic add(input logic [4:0] op, input logic [31:0] a, input logic [31:0] d,
                     input logic [5:0] dst, input logic [2:0] tk);
    ent_t e;
    e.op = op; e.addr = a; e.data = d; e.dest = dst; e.tk = tk;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_ready = 1'b1; exp_busy = 1'b0; exp_saddr = 32'h0; exp_inv = 1'b0;
    exp_rsp = 1'b0; exp_lw = 1'b0;
  endtask

  task automatic set_busy_exp(input logic [31:0] la);
    exp_ready = 1'b0; exp_busy = 1'b1; exp_saddr = la; exp_inv = 1'b0;
    exp_rsp = 1'b0; exp_lw = 1'b0;
  endtask

  task automatic junk_fill(input bit hold);
    fill_valid = hold;
    if (hold) begin
      fill_address = $urandom;
      fill_line = rand_line();
    end
  endtask

  task automatic present(input ent_t e, input bit more);
    wb_entry_microop  = e.op;
    wb_entry_address  = e.addr;
    wb_entry_data     = e.data;
    wb_entry_dest     = e.dest;
    wb_entry_ticket   = e.tk;
    wb_entry_is_store = (e.op >= 5'd6 && e.op <= 5'd8);
    wb_found_multi    = more;
  endtask

  // One full drain: fill cycle, ISSUE, one cycle per queued entry, WRITE
  task automatic run_txn(input logic [31:0] a, input logic [255:0] l, input bit hold);
    int n;
    logic [31:0] la;
    n = q.size();
    la = {a[31:5], 5'b0};
    tick();
    fill_valid = 1'b1; fill_address = a; fill_line = l;
    wb_found_one = (n > 0); wb_found_multi = 1'b0;
    set_idle_exp();
    for (int k = 0; k < 32; k++) m[k] = l[8*k +: 8];
    tick();
    junk_fill(hold);
    set_busy_exp(la);
    exp_inv = (n > 0);
    for (int i = 0; i < n; i++) begin
      tick();
      junk_fill(hold);
      present(q[i], i < n - 1);
      set_busy_exp(la);
      exp_rsp = (q[i].op >= 5'd1 && q[i].op <= 5'd5);
      exp_rdata = model_load(q[i]);
      exp_rdest = q[i].dest;
      exp_rtk = q[i].tk;
      model_store(q[i]);
    end
    tick();
    junk_fill(hold);
    wb_found_one = 1'b0; wb_found_multi = 1'b0;
    set_busy_exp(la);
    exp_lw = 1'b1; exp_lwaddr = la; exp_lwdata = pack_line();
    q.delete();
  endtask

  task automatic idle_tick();
    tick();
    fill_valid = 1'b0; wb_found_one = 1'b0; wb_found_multi = 1'b0;
    set_idle_exp();
  endtask

  // Cycle-by-cycle comparison against the model expectations
  always @(negedge clk) begin
    chk("fill_ready", fill_ready, exp_ready);
    chk("busy", busy, exp_busy);
    chk("search_address", wb_search_address, exp_saddr);
    chk("search_invalidate", wb_search_invalidate, exp_inv);
    chk("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp) begin
      chk("rsp_data", rsp_data, exp_rdata);
      chk("rsp_dest", rsp_dest, exp_rdest);
      chk("rsp_ticket", rsp_ticket, exp_rtk);
    end
    chk("line_wr_valid", line_wr_valid, exp_lw);
    if (exp_lw) begin
      chk("line_wr_address", line_wr_address, exp_lwaddr);
      chk("line_wr_data", line_wr_data, exp_lwdata);
    end
    if (rsp_valid === 1'b1) begin rsp_cnt++; last_rsp = rsp_data; end
    if (line_wr_valid === 1'b1) begin lw_cnt++; last_line = line_wr_data; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int ops [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 9, 31};

  initial begin
    logic [255:0] l;
    int rs, ls;
    #1 rst_n = 1'b0;
    set_idle_exp();
    #21 rst_n = 1'b1;

    // No match: written back unchanged two cycles after acceptance
    l = rand_line();
    ls = lw_cnt;
    run_txn(32'h0000_1040, l, 1'b0);
    idle_tick();
    chk("nomatch_line", last_line, l);
    chk("nomatch_writes", 32'(lw_cnt - ls), 32'd1);

    // Single LB / LBU of byte 0x80
    l = rand_line(); l[71:64] = 8'h80;
    add(5'd4, 32'h0000_1048, 32'h0, 6'd5, 3'd2);
    run_txn(32'h0000_1040, l, 1'b0);
    idle_tick();
    chk("lb_literal", last_rsp, 32'hFFFF_FF80);
    add(5'd5, 32'h0000_1048, 32'h0, 6'd5, 3'd2);
    run_txn(32'h0000_1040, l, 1'b0);
    idle_tick();
    chk("lbu_literal", last_rsp, 32'h0000_0080);

    // Store then load in the same walk
    add(5'd6, 32'h0000_104C, 32'hDEAD_BEEF, 6'd1, 3'd1);
    add(5'd2, 32'h0000_104E, 32'h0, 6'd9, 3'd4);
    run_txn(32'h0000_1040, rand_line(), 1'b0);
    idle_tick();
    chk("sw_lh_literal", last_rsp, 32'hFFFF_DEAD);
    chk("sw_line_literal", last_line[127:96], 32'hDEAD_BEEF);

    // Overlapping stores applied in presentation order
    rs = rsp_cnt; ls = lw_cnt;
    add(5'd6, 32'h0000_1050, 32'h1122_3344, 6'd0, 3'd0);
    add(5'd7, 32'h0000_1052, 32'h0000_5566, 6'd0, 3'd0);
    add(5'd8, 32'h0000_1053, 32'h0000_0077, 6'd0, 3'd0);
    run_txn(32'h0000_1040, rand_line(), 1'b0);
    idle_tick();
    chk("stores_literal", last_line[159:128], 32'h7766_3344);
    chk("stores_no_rsp", 32'(rsp_cnt - rs), 32'd0);
    chk("stores_one_write", 32'(lw_cnt - ls), 32'd1);

    // Back-to-back fills with fill_valid held high throughout
    add(5'd1, 32'h0000_2004, 32'h0, 6'd3, 3'd3);
    run_txn(32'h0000_2000, rand_line(), 1'b1);
    run_txn(32'h0000_3020, rand_line(), 1'b1);
    idle_tick();

    // Reset during the second WALK cycle
    ls = lw_cnt;
    add(5'd6, 32'h0000_4000, $urandom, 6'd1, 3'd1);
    add(5'd1, 32'h0000_4000, 32'h0, 6'd2, 3'd2);
    add(5'd1, 32'h0000_4004, 32'h0, 6'd3, 3'd3);
    tick();
    fill_valid = 1'b1; fill_address = 32'h0000_4000; fill_line = rand_line();
    wb_found_one = 1'b1; set_idle_exp();
    tick();
    fill_valid = 1'b0; set_busy_exp(32'h0000_4000); exp_inv = 1'b1;
    tick();
    present(q[0], 1'b1); set_busy_exp(32'h0000_4000);
    tick();
    present(q[1], 1'b1);
    set_idle_exp();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_fill_ready", fill_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_search_address", wb_search_address, 32'h0);
    #3 rst_n = 1'b1;
    q.delete();
    wb_found_one = 1'b0; wb_found_multi = 1'b0;
    idle_tick(); idle_tick(); idle_tick();
    chk("rst_no_line_write", 32'(lw_cnt - ls), 32'd0);

    // Randomised drains, including foreign-tag and unknown-microop entries
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      int n;
      a = $urandom;
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        logic [31:0] ea;
        ea = ($urandom_range(0, 7) == 0) ? $urandom : {a[31:5], 5'($urandom_range(0, 31))};
        add(5'(ops[$urandom_range(0, 10)]), ea, $urandom, 6'($urandom_range(0, 63)),
            3'($urandom_range(0, 7)));
      end
      run_txn(a, rand_line(), $urandom_range(0, 3) == 0);
    end
    idle_tick();
    idle_tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
